regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the SOIN-RV core: `NRD` combinational read ports, two synchronous write ports (ALU/load writeback) and a per-register busy scoreboard used by the issue stage to detect RAW hazards. Register 0 is hardwired to zero. The block optionally forwards same-cycle write data to the read ports. It replaces the single-write, non-resettable register file in the decode stage.

---
 rtl/regfile_mp.sv | 91 +++++++++
 tb/tb_regfile_mp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with two write ports and a busy scoreboard
// x0 reads as zero; write port 1 wins collisions; busy count kept incrementally.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NRD*AW-1:0]    i_Rnum,
  output logic [NRD*WIDTH-1:0] o_Rd,
  output logic [NRD-1:0]       o_Rbusy,
  input  logic                 i_Wen0,
  input  logic [AW-1:0]        i_Wnum0,
  input  logic [WIDTH-1:0]     i_Wd0,
  input  logic                 i_Wen1,
  input  logic [AW-1:0]        i_Wnum1,
  input  logic [WIDTH-1:0]     i_Wd1,
  input  logic                 i_Resv,
  input  logic [AW-1:0]        i_Resvnum,
  output logic                 o_Resv_ok,
  output logic [AW:0]          o_Busy_cnt
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW:0]      busy_cnt;

  logic wr0, wr1, resv_written, resv_inc, clr0, clr1;
  logic [AW:0] cnt_next;

  assign wr0 = i_Wen0 & (i_Wnum0 != '0);
  assign wr1 = i_Wen1 & (i_Wnum1 != '0);

  // A busy register may be re-reserved only while it is being written back (WAW).
  assign resv_written = (wr0 & (i_Wnum0 == i_Resvnum)) | (wr1 & (i_Wnum1 == i_Resvnum));
  assign o_Resv_ok    = i_Resv & (i_Resvnum != '0) & ~(busy[i_Resvnum] & ~resv_written);

  // Reservation has priority over a clear, so a reserved-and-written register nets to zero change.
  assign resv_inc = o_Resv_ok & ~busy[i_Resvnum];
  assign clr0     = wr0 & busy[i_Wnum0] & ~(o_Resv_ok & (i_Resvnum == i_Wnum0));
  assign clr1     = wr1 & busy[i_Wnum1] & ~(o_Resv_ok & (i_Resvnum == i_Wnum1))
                    & ~(wr0 & (i_Wnum0 == i_Wnum1));
  assign cnt_next = busy_cnt + (AW+1)'(resv_inc) - (AW+1)'(clr0) - (AW+1)'(clr1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr0) regs[i_Wnum0] <= i_Wd0;
      if (wr1) regs[i_Wnum1] <= i_Wd1;
      for (int r = 1; r < NREGS; r++) begin
        if (o_Resv_ok && i_Resvnum == AW'(r))
          busy[r] <= 1'b1;
        else if ((wr0 && i_Wnum0 == AW'(r)) || (wr1 && i_Wnum1 == AW'(r)))
          busy[r] <= 1'b0;
      end
      busy_cnt <= cnt_next;
    end
  end

  assign o_Busy_cnt = busy_cnt;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd;
    logic             rb;
    assign addr = i_Rnum[k*AW +: AW];
    always_comb begin
      rd = regs[addr];
      rb = busy[addr];
      if (addr == '0) begin
        rd = '0;
        rb = 1'b0;
      end else if (BYPASS != 0 && i_rst_n && wr1 && i_Wnum1 == addr) begin
        rd = i_Wd1;
        rb = 1'b0;
      end else if (BYPASS != 0 && i_rst_n && wr0 && i_Wnum0 == addr) begin
        rd = i_Wd0;
        rb = 1'b0;
      end
    end
    assign o_Rd[k*WIDTH +: WIDTH] = rd;
    assign o_Rbusy[k]             = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed check of regfile_mp against an array model
// Two instances share stimulus: one with write bypass, one without.
module tb_regfile_mp;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                 i_rst_n;
  logic [NRD*AW-1:0]    i_Rnum;
  logic                 i_Wen0, i_Wen1, i_Resv;
  logic [AW-1:0]        i_Wnum0, i_Wnum1, i_Resvnum;
  logic [WIDTH-1:0]     i_Wd0, i_Wd1;
  logic [NRD*WIDTH-1:0] rd_b, rd_n;
  logic [NRD-1:0]       rbusy_b, rbusy_n;
  logic                 resv_ok_b, resv_ok_n;
  logic [AW:0]          cnt_b, cnt_n;

  regfile_mp #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Rnum(i_Rnum), .o_Rd(rd_b), .o_Rbusy(rbusy_b),
    .i_Wen0(i_Wen0), .i_Wnum0(i_Wnum0), .i_Wd0(i_Wd0),
    .i_Wen1(i_Wen1), .i_Wnum1(i_Wnum1), .i_Wd1(i_Wd1),
    .i_Resv(i_Resv), .i_Resvnum(i_Resvnum), .o_Resv_ok(resv_ok_b), .o_Busy_cnt(cnt_b));

  regfile_mp #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Rnum(i_Rnum), .o_Rd(rd_n), .o_Rbusy(rbusy_n),
    .i_Wen0(i_Wen0), .i_Wnum0(i_Wnum0), .i_Wd0(i_Wd0),
    .i_Wen1(i_Wen1), .i_Wnum1(i_Wnum1), .i_Wd1(i_Wd1),
    .i_Resv(i_Resv), .i_Resvnum(i_Resvnum), .o_Resv_ok(resv_ok_n), .o_Busy_cnt(cnt_n));

  logic [WIDTH-1:0] mem [NREGS];
  bit               busy_m [NREGS];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int popcount();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(busy_m[r]);
    return n;
  endfunction

  function automatic bit written(input logic [AW-1:0] a);
    return (a != 0) && ((i_Wen0 && i_Wnum0 == a) || (i_Wen1 && i_Wnum1 == a));
  endfunction

  function automatic bit exp_resv_ok();
    return i_Resv && i_Resvnum != 0 && !(busy_m[i_Resvnum] && !written(i_Resvnum));
  endfunction

  task automatic set_in(input bit w0, input int n0, input logic [31:0] d0,
                        input bit w1, input int n1, input logic [31:0] d1,
                        input bit rv, input int rn, input int ra0, input int ra1);
    i_Wen0 = w0; i_Wnum0 = AW'(n0); i_Wd0 = d0;
    i_Wen1 = w1; i_Wnum1 = AW'(n1); i_Wd1 = d1;
    i_Resv = rv; i_Resvnum = AW'(rn);
    i_Rnum = {AW'(ra1), AW'(ra0)};
  endtask

  task automatic idle(input int ra0, input int ra1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  // Checks every output against the model mid-cycle, then advances one edge.
  task automatic cycle();
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] eb, en;
    bit               bb, bn, ok;
    #3;
    for (int k = 0; k < NRD; k++) begin
      a  = i_Rnum[k*AW +: AW];
      en = (a == 0 || !i_rst_n) ? '0 : mem[a];
      bn = (a == 0 || !i_rst_n) ? 1'b0 : busy_m[a];
      eb = en; bb = bn;
      if (i_rst_n && a != 0 && written(a)) begin
        eb = (i_Wen1 && i_Wnum1 == a) ? i_Wd1 : i_Wd0;
        bb = 1'b0;
      end
      check($sformatf("rd_byp[%0d]", k), rd_b[k*WIDTH +: WIDTH], eb);
      check($sformatf("rbusy_byp[%0d]", k), WIDTH'(rbusy_b[k]), WIDTH'(bb));
      check($sformatf("rd_nobyp[%0d]", k), rd_n[k*WIDTH +: WIDTH], en);
      check($sformatf("rbusy_nobyp[%0d]", k), WIDTH'(rbusy_n[k]), WIDTH'(bn));
    end
    ok = exp_resv_ok();
    check("resv_ok", WIDTH'(resv_ok_b), WIDTH'(ok));
    check("resv_ok_nb", WIDTH'(resv_ok_n), WIDTH'(ok));
    check("busy_cnt", WIDTH'(cnt_b), WIDTH'(popcount()));
    check("busy_cnt_nb", WIDTH'(cnt_n), WIDTH'(popcount()));
    @(posedge i_clk);
    if (i_rst_n) begin
      if (i_Wen0 && i_Wnum0 != 0) begin mem[i_Wnum0] = i_Wd0; busy_m[i_Wnum0] = 0; end
      if (i_Wen1 && i_Wnum1 != 0) begin mem[i_Wnum1] = i_Wd1; busy_m[i_Wnum1] = 0; end
      if (ok) busy_m[i_Resvnum] = 1;
    end
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin mem[r] = '0; busy_m[r] = 0; end
  endtask

  initial begin
    model_reset();
    i_rst_n = 1'b0;
    idle(0, 0);
    @(posedge i_clk); #1;
    cycle();
    i_rst_n = 1'b1;
    idle(0, 1);
    cycle();

    // x0 is neither writable nor reservable
    set_in(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
    #2 check("x0_resv_ok", WIDTH'(resv_ok_b), 0);
    cycle();
    idle(0, 0);
    cycle();
    check("x0_cnt", WIDTH'(cnt_b), 0);

    // scoreboard on x3
    set_in(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    cycle();
    idle(3, 3);
    #2 check("x3_rbusy", WIDTH'(rbusy_b[0]), 1);
    check("x3_cnt", WIDTH'(cnt_b), 1);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    #2 check("x3_rerev", WIDTH'(resv_ok_b), 0);
    cycle();
    set_in(1, 3, 32'h5A, 0, 0, 0, 0, 0, 3, 0);
    cycle();
    idle(3, 0);
    #2 check("x3_data", rd_b[WIDTH-1:0], 32'h5A);
    check("x3_cnt0", WIDTH'(cnt_b), 0);
    cycle();

    // reserve and write the same busy register on one edge
    set_in(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    cycle();
    set_in(0, 0, 0, 1, 4, 32'h44, 1, 4, 4, 0);
    #2 check("x4_waw_ok", WIDTH'(resv_ok_b), 1);
    cycle();
    idle(4, 0);
    #2 check("x4_still_busy", WIDTH'(rbusy_b[0]), 1);
    check("x4_cnt", WIDTH'(cnt_b), 1);
    check("x4_data", rd_b[WIDTH-1:0], 32'h44);
    cycle();
    set_in(1, 4, 32'h4, 0, 0, 0, 0, 0, 4, 0);
    cycle();

    // dual-write collision
    set_in(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
    #2 check("x7_byp", rd_b[WIDTH-1:0], 32'h22);
    check("x7_nobyp_old", rd_n[WIDTH-1:0], 32'h0);
    cycle();
    idle(7, 0);
    #2 check("x7_after", rd_n[WIDTH-1:0], 32'h22);
    cycle();

    // counter sweep up then down
    for (int r = 1; r < NREGS; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, r, r, r - 1);
      cycle();
    end
    check("sweep_full", WIDTH'(cnt_b), NREGS - 1);
    for (int r = 1; r < NREGS; r += 2) begin
      set_in(1, r, $urandom, r + 1 < NREGS, r + 1, $urandom, 0, 0, r, r + 1);
      cycle();
    end
    check("sweep_empty", WIDTH'(cnt_b), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, NREGS - 1), $urandom,
             $urandom_range(0, 1), $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, NREGS - 1), $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, NREGS - 1),
             $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
      if (i % 5 == 0) begin i_Wnum1 = i_Wnum0; i_Resvnum = i_Wnum0; end
      cycle();
    end

    // asynchronous reset between edges discards the pending write
    set_in(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1, 9, 5, 0);
    cycle();
    set_in(0, 0, 0, 1, 6, 32'h1234_5678, 1, 10, 5, 6);
    #2 i_rst_n = 1'b0;
    #1 check("rst_x5", rd_b[WIDTH-1:0], 0);
    check("rst_x6_byp", rd_b[2*WIDTH-1:WIDTH], 0);
    check("rst_cnt", WIDTH'(cnt_b), 0);
    model_reset();
    cycle();
    i_rst_n = 1'b1;
    idle(5, 6);
    cycle();
    check("post_rst_cnt", WIDTH'(cnt_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
